// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access unit and its decoder.
package csr_pkg;

  // Operation codes on the CSR file bus; any non-read code commits on the clock edge.
  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  // Zicsr funct3 encodings; 000 and 100 are not CSR instructions.
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

  // CSR address fields: minimum privilege and read-only space marker.
  localparam int         CSR_PRIV_MSB = 9;
  localparam int         CSR_PRIV_LSB = 8;
  localparam int         CSR_RO_MSB   = 11;
  localparam int         CSR_RO_LSB   = 10;
  localparam logic [1:0] CSR_RO_SPACE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP,
    ST_EXC
  } csr_acc_state_e;

endpackage

// File: rtl/csr_access_decode.sv
// Combinational decode of a latched Zicsr instruction: bus op, write operand,
// whether a write access is needed, and the illegality known without the CSR file.
module csr_access_decode
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            funct3,
  input  logic [4:0]            rs1_idx,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [11:0]           addr,
  input  logic [1:0]            priv_mode,
  output csr_op_e               op,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  do_write,
  output logic                  static_illegal
);

  logic funct3_bad;

  // Map funct3 to the bus op; set/clear with rs1/zimm of zero are pure reads.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    op         = CSR_READ;
    do_write   = 1'b0;
    funct3_bad = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: begin
        op       = CSR_WRITE;
        do_write = 1'b1;
      end
      F3_CSRRS, F3_CSRRSI: begin
        op       = CSR_SET;
        do_write = (rs1_idx != 5'd0);
      end
      F3_CSRRC, F3_CSRRCI: begin
        op       = CSR_CLEAR;
        do_write = (rs1_idx != 5'd0);
      end
      default: funct3_bad = 1'b1;
    endcase
  end

  // Immediate variants carry the zero-extended zimm in the rs1 field.
  assign operand = funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx} : rs1_data;

  assign static_illegal = funct3_bad
                       || (addr[CSR_PRIV_MSB:CSR_PRIV_LSB] > priv_mode)
                       || (do_write && (addr[CSR_RO_MSB:CSR_RO_LSB] == CSR_RO_SPACE));

endmodule

// File: rtl/csr_access_unit.sv
// Serialising CSR initiator: read the old value, optionally issue one
// write/set/clear cycle, then hand the old value to writeback or raise an
// illegal-instruction exception.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1_idx,
  input  logic [DATA_WIDTH-1:0] req_rs1_data,
  input  logic [11:0]           req_csr_addr,
  input  logic [DATA_WIDTH-1:0] req_pc,
  input  logic [31:0]           req_instr,
  input  logic [1:0]            priv_mode,
  input  logic                  flush,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_write_data,
  output logic [1:0]            csr_op,
  input  logic [DATA_WIDTH-1:0] csr_read_data,
  input  logic                  csr_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  exc_valid,
  output logic [3:0]            exc_code,
  output logic [DATA_WIDTH-1:0] exc_value,
  output logic [DATA_WIDTH-1:0] exc_pc
);

  csr_acc_state_e        state_q, state_d;
  logic [2:0]            funct3_q;
  logic [4:0]            rd_q;
  logic [4:0]            rs1_idx_q;
  logic [DATA_WIDTH-1:0] rs1_data_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [31:0]           instr_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  csr_op_e               dec_op;
  logic [DATA_WIDTH-1:0] dec_operand;
  logic                  dec_do_write;
  logic                  dec_static_illegal;
  logic                  accept;
  logic                  illegal;
  logic                  write_active;

  csr_access_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .funct3         (funct3_q),
    .rs1_idx        (rs1_idx_q),
    .rs1_data       (rs1_data_q),
    .addr           (addr_q),
    .priv_mode      (priv_mode),
    .op             (dec_op),
    .operand        (dec_operand),
    .do_write       (dec_do_write),
    .static_illegal (dec_static_illegal)
  );

  // A flush in IDLE blocks acceptance even though req_ready stays high.
  assign accept  = (state_q == ST_IDLE) && req_valid && !flush;
  assign illegal = csr_error || dec_static_illegal;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one READ, optional single WRITE, then RESP or EXC; flush aborts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ: begin
        if (flush)             state_d = ST_IDLE;
        else if (illegal)      state_d = ST_EXC;
        else if (dec_do_write) state_d = ST_WRITE;
        else                   state_d = ST_RESP;
      end
      ST_WRITE: state_d = flush ? ST_IDLE : ST_RESP;
      ST_RESP:  if (flush || rsp_ready) state_d = ST_IDLE;
      ST_EXC:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance; later changes on req_* are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these latches feed outputs directly, so they are reset to keep outputs at 0.
    if (!rst_n) begin
      funct3_q   <= '0;
      rd_q       <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      addr_q     <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else if (accept) begin
      funct3_q   <= req_funct3;
      rd_q       <= req_rd;
      rs1_idx_q  <= req_rs1_idx;
      rs1_data_q <= req_rs1_data;
      addr_q     <= req_csr_addr;
      pc_q       <= req_pc;
      instr_q    <= req_instr;
    end
  end

  // Hold the old CSR value read during READ for writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rsp_data_q <= '0;
    else if (state_q == ST_READ) rsp_data_q <= csr_read_data;
  end

  // The CSR file commits any non-read op each edge, so only an unflushed WRITE drives one.
  assign write_active   = (state_q == ST_WRITE) && !flush;
  assign csr_op         = write_active ? dec_op : CSR_READ;
  assign csr_write_data = write_active ? dec_operand : '0;
  assign csr_addr       = ((state_q == ST_READ) || (state_q == ST_WRITE)) ? addr_q : 12'd0;

  assign req_ready = (state_q == ST_IDLE);

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rd    = rd_q;
  assign rsp_we    = (rd_q != 5'd0);
  assign rsp_data  = rsp_data_q;

  assign exc_valid = (state_q == ST_EXC) && !flush;
  assign exc_code  = exc_valid ? EXC_ILLEGAL_INSTR : 4'd0;
  assign exc_value = {{(DATA_WIDTH-32){1'b0}}, instr_q};
  assign exc_pc    = pc_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: a reference model pushes the expected
// bus write, writeback response or exception per instruction; a monitor pops
// and compares whenever the DUT presents one.
module tb_csr_access_unit;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [2:0]    req_funct3;
  logic [4:0]    req_rd, req_rs1_idx;
  logic [DW-1:0] req_rs1_data, req_pc;
  logic [11:0]   req_csr_addr;
  logic [31:0]   req_instr;
  logic [1:0]    priv_mode;
  logic          flush;
  logic [11:0]   csr_addr;
  logic [DW-1:0] csr_write_data, csr_read_data;
  logic [1:0]    csr_op;
  logic          csr_error;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [4:0]    rsp_rd;
  logic [DW-1:0] rsp_data;
  logic          exc_valid;
  logic [3:0]    exc_code;
  logic [DW-1:0] exc_value, exc_pc;

  csr_access_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
    .req_csr_addr(req_csr_addr), .req_pc(req_pc), .req_instr(req_instr),
    .priv_mode(priv_mode), .flush(flush),
    .csr_addr(csr_addr), .csr_write_data(csr_write_data), .csr_op(csr_op),
    .csr_read_data(csr_read_data), .csr_error(csr_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_value(exc_value), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // CSR file model: fixed contents; addresses with [7:4]==C are unimplemented.
  function automatic logic [63:0] csr_value(input logic [11:0] a);
    return (a == 12'h340) ? 64'hAB : {a, 40'h5A5AC3C30F, a};
  endfunction
  function automatic logic csr_unimpl(input logic [11:0] a);
    return a[7:4] == 4'hC;
  endfunction
  assign csr_read_data = csr_value(csr_addr);
  assign csr_error     = csr_unimpl(csr_addr);

  typedef enum int {EV_WRITE, EV_RSP, EV_EXC} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          cyc;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic [63:0] value;
    logic [63:0] pc;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [63:0] rs1_data;
    logic [11:0] addr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [1:0]  priv;
  } req_t;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the architectural outcome of one CSR instruction.
  task automatic push_expected(input req_t r, input int c);
    ev_t         e;
    logic [1:0]  kind;
    logic        writes, bad;
    logic [63:0] opnd;
    kind   = r.f3[1:0];  // 1 write, 2 set, 3 clear, 0 not a CSR op
    writes = (kind == 2'd1) || (r.rs1 != 5'd0);
    opnd   = r.f3[2] ? {59'd0, r.rs1} : r.rs1_data;
    bad    = (kind == 2'd0) || csr_unimpl(r.addr) || (r.addr[9:8] > r.priv)
          || (writes && (r.addr[11:10] == 2'b11));
    if (bad) begin
      e.kind = EV_EXC; e.cyc = c + 2;
      e.value = {32'd0, r.instr}; e.pc = r.pc;
      sb.push_back(e);
    end else begin
      if (writes) begin
        e.kind = EV_WRITE; e.cyc = c + 2;
        e.addr = r.addr; e.op = kind; e.wdata = opnd;
        sb.push_back(e);
      end
      e.kind = EV_RSP; e.cyc = c + (writes ? 3 : 2);
      e.rd = r.rd; e.we = (r.rd != 5'd0); e.data = csr_value(r.addr);
      sb.push_back(e);
    end
  endtask

  function automatic req_t mk(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [63:0] d, input logic [11:0] a, input logic [1:0] p);
    req_t r;
    r.f3 = f3; r.rd = rd; r.rs1 = rs1; r.rs1_data = d; r.addr = a; r.priv = p;
    r.pc = {$urandom, $urandom}; r.instr = $urandom;
    return r;
  endfunction

  // Present one request when IDLE; afterwards scramble req_* to prove they were latched.
  task automatic issue(input req_t r, input bit track);
    int waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!req_ready && waited < 200);
    if (!req_ready) begin
      check("issue_ready_timeout", 64'(req_ready), 64'd1);
    end else begin
      req_funct3 = r.f3; req_rd = r.rd; req_rs1_idx = r.rs1; req_rs1_data = r.rs1_data;
      req_csr_addr = r.addr; req_pc = r.pc; req_instr = r.instr; priv_mode = r.priv;
      req_valid = 1'b1;
      if (track) push_expected(r, cyc);
      @(posedge clk); #1;
      req_valid    = 1'b0;
      req_funct3   = 3'($urandom);
      req_rd       = 5'($urandom);
      req_rs1_idx  = 5'($urandom);
      req_rs1_data = {$urandom, $urandom};
      req_csr_addr = 12'($urandom);
      req_pc       = {$urandom, $urandom};
      req_instr    = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Writeback backpressure driver.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every bus write, exception pulse and response against the scoreboard.
  initial begin
    bit          prev_valid, prev_stall, prev_hs;
    logic [4:0]  s_rd;
    logic        s_we;
    logic [63:0] s_data;
    prev_valid = 0; prev_stall = 0; prev_hs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0; prev_stall = 0; prev_hs = 0;
      end else begin
        if (prev_hs) check("ready_after_rsp", 64'(req_ready), 64'd1);
        if (csr_op != 2'b00) begin
          if (sb.size() > 0 && sb[0].kind == EV_WRITE) begin
            check("wr_op",    64'(csr_op),   64'(sb[0].op));
            check("wr_addr",  64'(csr_addr), 64'(sb[0].addr));
            check("wr_data",  csr_write_data, sb[0].wdata);
            check("wr_cycle", 64'(cyc),      64'(sb[0].cyc));
            void'(sb.pop_front());
          end else begin
            check("op_without_write", 64'(csr_op), 64'd0);
          end
        end
        if (exc_valid) begin
          if (sb.size() > 0 && sb[0].kind == EV_EXC) begin
            check("exc_code",  64'(exc_code), 64'd2);
            check("exc_value", exc_value,     sb[0].value);
            check("exc_pc",    exc_pc,        sb[0].pc);
            check("exc_cycle", 64'(cyc),      64'(sb[0].cyc));
            void'(sb.pop_front());
          end else begin
            check("exc_unexpected", 64'(exc_valid), 64'd0);
          end
        end
        if (rsp_valid) begin
          check("busy_while_rsp", 64'(req_ready), 64'd0);
          if (sb.size() == 0 || sb[0].kind != EV_RSP) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            if (!prev_valid) check("rsp_cycle", 64'(cyc), 64'(sb[0].cyc));
            if (prev_stall) begin
              check("rsp_stable_rd",   64'(rsp_rd), 64'(s_rd));
              check("rsp_stable_we",   64'(rsp_we), 64'(s_we));
              check("rsp_stable_data", rsp_data,    s_data);
            end
            if (rsp_ready) begin
              check("rsp_rd",   64'(rsp_rd), 64'(sb[0].rd));
              check("rsp_we",   64'(rsp_we), 64'(sb[0].we));
              check("rsp_data", rsp_data,    sb[0].data);
              void'(sb.pop_front());
            end
          end
        end
        prev_hs    = rsp_valid && rsp_ready;
        prev_stall = rsp_valid && !rsp_ready;
        prev_valid = rsp_valid;
        s_rd = rsp_rd; s_we = rsp_we; s_data = rsp_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  // Main stimulus sequence.
  initial begin
    req_t r;
    int   n;
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; priv_mode = 2'd3;
    req_funct3 = '0; req_rd = '0; req_rs1_idx = '0; req_rs1_data = '0;
    req_csr_addr = '0; req_pc = '0; req_instr = '0;
    #1;
    check("reset_ctrl", 64'({rsp_valid, rsp_we, rsp_rd, exc_valid, exc_code, csr_op, csr_addr}), 64'd0);
    check("reset_data", rsp_data | csr_write_data | exc_value | exc_pc, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, writeback always ready.
    rdy_mode = 2;
    issue(mk(3'b001, 5'd5, 5'd1, 64'h100, 12'h340, 2'd3), 1'b1);  // CSRRW: write 0x100, old 0xAB
    issue(mk(3'b010, 5'd4, 5'd0, 64'hDEAD, 12'hC00, 2'd3), 1'b1); // CSRRS x0: read only
    issue(mk(3'b111, 5'd6, 5'd8, 64'hFFFF, 12'h300, 2'd3), 1'b1); // CSRRCI zimm 8
    issue(mk(3'b101, 5'd2, 5'd3, 64'h0, 12'hF11, 2'd3), 1'b1);    // CSRRWI to read-only space
    issue(mk(3'b010, 5'd1, 5'd0, 64'h0, 12'h7C0, 2'd3), 1'b1);    // unimplemented address
    issue(mk(3'b010, 5'd1, 5'd0, 64'h0, 12'h300, 2'd0), 1'b1);    // privilege too low
    issue(mk(3'b100, 5'd1, 5'd0, 64'h0, 12'h340, 2'd3), 1'b1);    // funct3 100
    issue(mk(3'b001, 5'd0, 5'd2, 64'h77, 12'h340, 2'd3), 1'b1);   // rd = x0: no reg write
    drain();

    // Backpressure: writeback stalls for 4 cycles.
    rdy_mode = 1;
    issue(mk(3'b010, 5'd7, 5'd0, 64'h0, 12'h340, 2'd3), 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("hold_rsp_seen", 64'(rsp_valid), 64'd1);
    repeat (4) @(negedge clk);
    rdy_mode = 2;
    issue(mk(3'b011, 5'd8, 5'd4, 64'h0F, 12'h340, 2'd1), 1'b1);  // back-to-back follow-up
    drain();

    // Flush during WRITE: the write must be suppressed and nothing reported.
    issue(mk(3'b001, 5'd3, 5'd9, 64'h55, 12'h340, 2'd3), 1'b0);
    @(posedge clk); #1;
    check("flush_pre_op", 64'(csr_op), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_write_op", 64'(csr_op), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_to_idle", 64'({req_ready, rsp_valid, exc_valid}), 64'b100);
    repeat (4) @(posedge clk);
    #1;

    // Flush in IDLE: request is not taken.
    check("idle_before_flush", 64'(req_ready), 64'd1);
    req_funct3 = 3'b001; req_rd = 5'd1; req_rs1_idx = 5'd1; req_csr_addr = 12'h340;
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    check("flush_idle_no_accept", 64'(req_ready), 64'd1);
    req_valid = 1'b0; flush = 1'b0;

    // Asynchronous reset while a response is pending.
    rdy_mode = 1;
    issue(mk(3'b010, 5'd9, 5'd0, 64'h0, 12'hC00, 2'd0), 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("rsp_before_reset", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_resp_ctrl", 64'({rsp_valid, rsp_we, rsp_rd, exc_valid, exc_code, csr_op, csr_addr}), 64'd0);
    check("rst_resp_data", rsp_data | csr_write_data, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Randomised traffic with random writeback backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      logic [11:0] a;
      case ($urandom_range(0, 7))
        0: a = 12'h340;
        1: a = 12'h300;
        2: a = 12'hC00;
        3: a = 12'hF11;
        4: a = 12'h7C0;
        5: a = 12'h141;
        default: a = 12'($urandom);
      endcase
      r = mk(3'($urandom),
             ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             {$urandom, $urandom}, a, 2'($urandom));
      issue(r, 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
